// File: rtl/neuron_pkg.sv
// Shared definitions for the single-neuron MAC engine: FSM states,
// activation select codes and the signed saturation helper.
package neuron_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   localparam logic [1:0] ACT_LINEAR = 2'd0;
   localparam logic [1:0] ACT_RELU   = 2'd1;
   localparam logic [1:0] ACT_STEP   = 2'd2;

   // Clamp v into the signed range of a width-bit number; callers cast down to width.
   function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                              input int unsigned width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/neuron_activation.sv
// Combinational activation stage: maps a signed accumulator value to the
// neuron result according to the selected activation mode.
module neuron_activation
   import neuron_pkg::*;
#(
   parameter int AW = 20,
   parameter int OW = 16
) (
   input  logic [AW-1:0] acc,
   input  logic [1:0]    mode,
   output logic [OW-1:0] result
);

   logic signed [63:0] acc_ext;

   always_comb begin
      acc_ext = 64'($signed(acc));
      case (mode)
         ACT_RELU: result = (acc_ext < 0) ? '0 : OW'(sat(acc_ext, OW));
         ACT_STEP: result = (acc_ext > 0) ? OW'(1) : '0;
         // Reserved code 3 falls back to linear.
         default:  result = OW'(sat(acc_ext, OW));
      endcase
   end

endmodule

// File: rtl/neuron_mac_unit.sv
// Single-neuron engine: registered signed multiplier feeding a saturating,
// bias-initialised accumulator, then activation and a valid/ready result port.
module neuron_mac_unit
   import neuron_pkg::*;
#(
   parameter int DW   = 8,
   parameter int AW   = 20,
   parameter int OW   = 16,
   parameter int N_IN = 16,
   parameter int CW   = $clog2(N_IN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] bias,
   input  logic [1:0]    act_mode,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] x_in,
   input  logic [DW-1:0] w_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] result,
   output logic          busy,
   output logic          overflow
);

   state_t                 state;
   state_t                 state_next;
   logic [CW-1:0]          cnt;
   logic signed [2*DW-1:0] prod;
   logic signed [2*DW-1:0] p_reg;
   logic                   p_vld;
   logic signed [AW-1:0]   acc;
   logic signed [AW-1:0]   acc_next;
   logic signed [63:0]     sum_ext;
   logic signed [63:0]     sum_sat;
   logic                   sat_hit;
   logic [1:0]             mode_r;
   logic                   hs;
   logic                   last_pair;
   logic [OW-1:0]          act_res;

   assign prod = (2*DW)'($signed(x_in)) * (2*DW)'($signed(w_in));

   // Handshake is derived from state directly so it does not loop through in_ready.
   assign hs        = in_valid && (state == ST_ACCUM);
   assign last_pair = hs && (cnt == CW'(N_IN - 1));

   assign sum_ext  = 64'(acc) + 64'(p_reg);
   assign sum_sat  = sat(sum_ext, AW);
   assign sat_hit  = (sum_sat != sum_ext);
   assign acc_next = p_vld ? AW'(sum_sat) : acc;

   neuron_activation #(
      .AW (AW),
      .OW (OW)
   ) u_act (
      .acc    (acc_next),
      .mode   (mode_r),
      .result (act_res)
   );

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b1;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_next = ST_ACCUM;
         end
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (last_pair) state_next = ST_DRAIN;
         end
         ST_DRAIN: state_next = ST_OUT;
         ST_OUT: begin
            if (out_valid && out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         p_reg     <= '0;
         p_vld     <= 1'b0;
         acc       <= '0;
         mode_r    <= ACT_LINEAR;
         result    <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state <= state_next;
         p_vld <= hs;
         if (hs) begin
            p_reg <= prod;
            cnt   <= cnt + CW'(1);
         end
         if (p_vld) begin
            acc <= acc_next;
            if (sat_hit) overflow <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc      <= $signed(bias);
                  cnt      <= '0;
                  overflow <= 1'b0;
                  mode_r   <= act_mode;
               end
            end
            ST_DRAIN: begin
               result    <= act_res;
               out_valid <= 1'b1;
            end
            ST_OUT: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Self-checking bench for neuron_mac_unit (N_IN=4): directed scenarios plus
// randomized evaluations compared against an arithmetic reference model.
module tb_neuron_mac_unit;

   localparam int DW = 8;
   localparam int AW = 20;
   localparam int OW = 16;
   localparam int N  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] bias = '0;
   logic [1:0]    act_mode = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] x_in = '0;
   logic [DW-1:0] w_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [OW-1:0] result;
   logic          busy;
   logic          overflow;

   int n_cmp = 0;
   int n_err = 0;
   int xs[N];
   int ws[N];

   always #5 clk = ~clk;

   neuron_mac_unit #(
      .DW   (DW),
      .AW   (AW),
      .OW   (OW),
      .N_IN (N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bias      (bias),
      .act_mode  (act_mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .w_in      (w_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint clampw(input longint v, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Reference: running sum with clamp after each product, as the accumulator is defined.
   function automatic void model(input longint b, output longint acc, output bit ovf);
      longint t;
      acc = b;
      ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
         t = clampw(acc + longint'(xs[i] * ws[i]), AW);
         if (t != acc + longint'(xs[i] * ws[i])) ovf = 1'b1;
         acc = t;
      end
   endfunction

   function automatic logic [OW-1:0] act(input longint a, input int mode);
      case (mode)
         1:       return (a < 0) ? '0 : OW'(clampw(a, OW));
         2:       return (a > 0) ? OW'(1) : '0;
         default: return OW'(clampw(a, OW));
      endcase
   endfunction

   task automatic run_eval(input string tag, input longint b, input int mode,
                           input int gmin, input int gmax, input int hold);
      longint        eacc;
      bit            eovf;
      logic [OW-1:0] eres;
      model(b, eacc, eovf);
      eres = act(eacc, mode);

      start    = 1'b1;
      bias     = AW'(b);
      act_mode = 2'(mode);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_ovf_clr"}, 64'(overflow), 64'd0);

      for (int i = 0; i < N; i++) begin
         repeat ($urandom_range(gmin, gmax)) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         in_valid = 1'b1;
         x_in     = DW'(xs[i]);
         w_in     = DW'(ws[i]);
         check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check({tag, "_lat1"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_lat2"}, 64'(out_valid), 64'd1);
      check({tag, "_result"}, 64'(result), 64'(eres));
      check({tag, "_overflow"}, 64'(overflow), 64'(eovf));

      for (int k = 0; k < hold; k++) begin
         start    = (k == 1);
         act_mode = ~act_mode;
         @(negedge clk);
         check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_hold_result"}, 64'(result), 64'(eres));
         check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
         check({tag, "_hold_busy"}, 64'(busy), 64'd1);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_done_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_done_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      longint b;

      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      xs = '{1, 2, 3, 4};   ws = '{1, 1, 1, 1};
      run_eval("t1", 0, 0, 0, 0, 0);

      xs = '{-5, -1, -2, -2};
      run_eval("t2_relu", 0, 1, 0, 0, 0);
      run_eval("t2_lin", 0, 0, 0, 0, 1);

      xs = '{-128, -128, -128, -128}; ws = '{-128, -128, -128, -128};
      run_eval("t3_sat", 524000, 0, 0, 0, 0);
      xs = '{7, -3, 2, 9}; ws = '{5, 6, -4, 1};
      run_eval("t3_clear", 100, 0, 0, 0, 0);

      xs = '{30, -20, 10, 5}; ws = '{3, 2, -7, 11};
      run_eval("t4_hold", 12, 0, 0, 0, 5);

      start    = 1'b1;
      bias     = '0;
      act_mode = '0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         x_in     = DW'(i + 1);
         w_in     = DW'(1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("t5_rst_valid", 64'(out_valid), 64'd0);
      check("t5_rst_in_ready", 64'(in_ready), 64'd0);
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_overflow", 64'(overflow), 64'd0);
      check("t5_rst_result", 64'(result), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      xs = '{1, 2, 3, 4};   ws = '{1, 1, 1, 1};
      run_eval("t5_fresh", 0, 0, 0, 0, 0);

      xs = '{1, 0, 0, 0};   ws = '{1, 1, 1, 1};
      run_eval("t6_step_pos", 0, 2, 0, 0, 0);
      run_eval("t6_step_pos_gap", 0, 2, 1, 1, 0);
      xs = '{0, 0, 0, 0};
      run_eval("t6_step_zero", 0, 2, 0, 0, 0);
      run_eval("t6_step_zero_gap", 0, 2, 1, 1, 0);

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < N; i++) begin
            xs[i] = int'($urandom_range(0, 255)) - 128;
            ws[i] = int'($urandom_range(0, 255)) - 128;
         end
         case ($urandom_range(0, 3))
            0:       b = 524287 - longint'($urandom_range(0, 40000));
            1:       b = -524288 + longint'($urandom_range(0, 40000));
            default: b = longint'($urandom_range(0, 4000)) - 2000;
         endcase
         run_eval("rand", b, int'($urandom_range(0, 3)), 0, 2, int'($urandom_range(0, 4)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
